// File: rtl/uart_duty_pwm.sv
// UART-commanded PWM: an 8N1 receiver feeds a 3-byte frame parser (0xA5, D, ~D)
// whose accepted duty value is applied to a free-running 255-step PWM at period wrap.
module uart_duty_pwm #(
  parameter int CLK_DIV = 434,
  parameter int PWM_PRE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic       PWM_Val,
  output logic [7:0] Duty,
  output logic       Cmd_Valid,
  output logic       Frame_Err
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PRE_W = (PWM_PRE > 1) ? $clog2(PWM_PRE) : 1;
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1 = DIV_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_M1  = PRE_W'(PWM_PRE - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_DUTY, P_CHK} prs_state_t;

  logic             r_rx_meta, r_rxs, r_rxs_d;
  rx_state_t        r_rx_state;
  logic [DIV_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift, r_byte;
  logic             r_byte_stb, r_stop_err;
  prs_state_t       r_prs_state;
  logic [7:0]       r_d, r_pend_duty;
  logic             r_cmd_valid, r_frame_err;
  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_cnt, r_duty;
  logic             r_pwm;
  logic             w_tick;

  // Synchronizer resets to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns these three lines into a shift chain.
      r_rx_meta <= RX;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_byte_stb <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_byte_stb <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rxs_d && !r_rxs) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt  <= '0;
            r_rx_state <= r_rxs ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rxs) begin
              r_byte_stb <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_stop_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A stop-bit error reaches Frame_Err through the same register as a checksum error,
  // so the two error sources can never double-pulse and never overlap Cmd_Valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prs_state <= P_HDR;
      r_d         <= '0;
      r_pend_duty <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= r_stop_err;
      if (r_stop_err) begin
        r_prs_state <= P_HDR;
      end else if (r_byte_stb) begin
        case (r_prs_state)
          P_HDR:  if (r_byte == 8'hA5) r_prs_state <= P_DUTY;
          P_DUTY: begin
            r_d         <= r_byte;
            r_prs_state <= P_CHK;
          end
          P_CHK: begin
            if (r_byte == ~r_d) begin
              r_pend_duty <= r_d;
              r_cmd_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_prs_state <= P_HDR;
          end
          default: r_prs_state <= P_HDR;
        endcase
      end
    end
  end

  assign w_tick = (r_pre == PRE_M1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_pwm <= (r_cnt < r_duty);
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        // Duty only moves at the period boundary so no PWM pulse is ever truncated.
        if (r_cnt == 8'd254) begin
          r_cnt  <= '0;
          r_duty <= r_pend_duty;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign PWM_Val   = r_pwm;
  assign Duty      = r_duty;
  assign Cmd_Valid = r_cmd_valid;
  assign Frame_Err = r_frame_err;

endmodule

// File: doc/uart_duty_pwm.md
UART_DUTY_PWM -- requirements
Module: uart_duty_pwm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 CLK_DIV, default 434, SHALL be the clocks per UART bit; the minimum legal value is 4.
REQ-003 PWM_PRE, default 8, SHALL be the clocks per PWM counter tick; the minimum legal value is 1.
REQ-004 CLK  input  1  system clock; all state changes on the rising edge.
REQ-005 RST  input  1  asynchronous reset, active low.
REQ-006 RX  input  1  UART serial in, 8N1, idle high; asynchronous to CLK.
REQ-007 PWM_Val  output  1  PWM drive to the downstream commutation stage.
REQ-008 Duty  output  8  duty value currently applied to PWM_Val.
REQ-009 Cmd_Valid  output  1  one-cycle pulse when a frame is accepted.
REQ-010 Frame_Err  output  1  one-cycle pulse on a stop-bit error or a checksum mismatch.

Function
REQ-011 RX SHALL pass through a 2-flop synchronizer; all later logic SHALL use only the synchronized value (rxs).
REQ-012 The receiver FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-013 IDLE->START SHALL occur on a 1->0 transition of rxs; the bit counter is cleared on entry.
REQ-014 START: after CLK_DIV/2 clocks (integer divide), the receiver SHALL sample rxs; low -> DATA, high -> IDLE (glitch rejected, no error).
REQ-015 DATA SHALL sample 8 bits, LSB first, each CLK_DIV clocks after the previous sample, then go to STOP.
REQ-016 STOP: CLK_DIV clocks after the last data bit, rxs high SHALL produce a one-cycle byte strobe; rxs low SHALL give a Frame_Err pulse and discard the byte.
REQ-017 After STOP the receiver SHALL always return to IDLE; a new start bit requires a fresh 1->0 edge.
REQ-018 The frame parser SHALL have the states HDR, DUTY and CHK; a frame is 0xA5, D, C.
REQ-019 HDR: a byte equal to 0xA5 SHALL advance the parser to DUTY; any other byte SHALL be ignored silently.
REQ-020 DUTY: the parser SHALL latch any byte as D and go to CHK; 0xA5 here is data, not a resync.
REQ-021 CHK: C == (D XOR 0xFF) SHALL load pend_duty <= D, pulse Cmd_Valid the same cycle and return to HDR.
REQ-022 CHK: a mismatch SHALL pulse Frame_Err, leave pend_duty unchanged and return to HDR.
REQ-023 A stop-bit error in any parser state SHALL return the parser to HDR; only the single Frame_Err pulse from REQ-016 is issued.
REQ-024 The prescaler SHALL produce a tick every PWM_PRE clocks.
REQ-025 On each tick, the 8-bit counter cnt SHALL step 0..254 and then wrap to 0, giving a period of 255 ticks.
REQ-026 PWM_Val SHALL be registered as (cnt < Duty).
REQ-027 Duty 0 SHALL give PWM_Val constantly low; Duty 255 SHALL give it constantly high.
REQ-028 Duty SHALL load from pend_duty only on the tick where cnt wraps 254->0 (glitch-free update).
REQ-029 If pend_duty is written in the same cycle as a wrap, the old pend_duty SHALL be applied and the new value takes effect at the next wrap.
REQ-030 Cmd_Valid and Frame_Err SHALL never be high in the same cycle.
REQ-031 Receiver latency SHALL be: byte strobe 1 cycle after the STOP sample; Cmd_Valid 1 cycle after the checksum byte strobe.

Reset
REQ-032 RST low SHALL immediately force: receiver IDLE; parser HDR.
REQ-033 RST low SHALL immediately force: synchronizer flops to 1; pend_duty, Duty, cnt and prescaler to 0.
REQ-034 RST low SHALL immediately force PWM_Val, Cmd_Valid and Frame_Err to 0.
REQ-035 Reset asserted mid-byte or mid-frame SHALL discard the partial data with no error pulse.
REQ-036 After RST release, the next frame SHALL be decoded normally.

Verification (CLK_DIV=16, PWM_PRE=1)
REQ-037 Frame A5,40,BF -> single Cmd_Valid; at the next wrap Duty=0x40; PWM_Val high for 64 of every 255 clocks.
REQ-038 Frame A5,40,00 -> single Frame_Err pulse, no Cmd_Valid, Duty unchanged.
REQ-039 Byte 0x55 with its stop bit driven low -> Frame_Err; a following frame A5,10,EF is still accepted with Duty=0x10.
REQ-040 A 4-clock low glitch on RX in IDLE -> no byte strobe, no error.
REQ-041 Frames for Duty 00 then FF -> PWM_Val constantly 0, then constantly 1 from the next wrap; Duty changes exactly on the 254->0 tick.
REQ-042 RST pulsed low after the 4th data bit of the duty byte -> all outputs 0 at once; the next full frame A5,80,7F gives Duty=0x80.
